// File: rtl/call_scheduler.sv
// rtl/call_scheduler.sv - SCAN request dispatcher driving the car controller's call input
module call_scheduler #(
    parameter int DWELL_CYCLES = 3,
    parameter int IDLE_TIMEOUT = 8,
    parameter int HOME_FLOOR   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_btn,
    input  logic [1:0] cur_floor,
    input  logic       door,
    input  logic       emergency,
    output logic [1:0] call,
    output logic [3:0] pending,
    output logic       dir_pref,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, MOVE, DWELL, HOMING} state_t;

    localparam logic [3:0] DWELL_L = 4'(DWELL_CYCLES);
    localparam logic [7:0] IDLE_L  = 8'(IDLE_TIMEOUT);
    localparam logic [1:0] HOME_L  = 2'(HOME_FLOOR);

    state_t     state_q, state_d;
    logic [1:0] call_q, call_d;
    logic [3:0] pending_q, pending_d;
    logic       dir_pref_q, dir_pref_d;
    logic       busy_q, busy_d;
    logic [3:0] dwell_cnt_q, dwell_cnt_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       home_hold_q, home_hold_d;

    logic [3:0] clear_mask, cur_onehot;
    logic [1:0] up_tgt, dn_tgt, tgt;
    logic       found_up, found_dn, tgt_valid, tgt_dir;

    assign cur_onehot = 4'b0001 << cur_floor;

    always_comb begin
        found_up = 1'b0;
        found_dn = 1'b0;
        up_tgt   = 2'd0;
        dn_tgt   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending_q[2'(i)]) begin
                if (2'(i) > cur_floor && !found_up) begin
                    up_tgt   = 2'(i);
                    found_up = 1'b1;
                end
                if (2'(i) < cur_floor) begin
                    dn_tgt   = 2'(i);
                    found_dn = 1'b1;
                end
            end
        end
        tgt_valid = 1'b1;
        tgt       = cur_floor;
        tgt_dir   = dir_pref_q;
        if (!pending_q[cur_floor]) begin
            if (dir_pref_q && found_up) begin
                tgt = up_tgt;
            end else if (!dir_pref_q && found_dn) begin
                tgt = dn_tgt;
            end else if (found_up) begin
                tgt     = up_tgt;
                tgt_dir = 1'b1;
            end else if (found_dn) begin
                tgt     = dn_tgt;
                tgt_dir = 1'b0;
            end else begin
                tgt_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        call_d      = call_q;
        dir_pref_d  = dir_pref_q;
        dwell_cnt_d = dwell_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        home_hold_d = home_hold_q;
        clear_mask  = 4'b0000;
        if (!emergency) begin
            unique case (state_q)
                IDLE, HOMING: begin
                    if (tgt_valid) begin
                        call_d     = tgt;
                        dir_pref_d = tgt_dir;
                        idle_cnt_d = 8'd0;
                        if (tgt == cur_floor) begin
                            state_d     = DWELL;
                            dwell_cnt_d = DWELL_L;
                        end else begin
                            state_d = MOVE;
                        end
                    end else if (state_q == HOMING) begin
                        call_d = HOME_L;
                        if (cur_floor == HOME_L) begin
                            state_d     = IDLE;
                            home_hold_d = 1'b1;
                            idle_cnt_d  = 8'd0;
                        end
                    end else begin
                        if (idle_cnt_q != IDLE_L) idle_cnt_d = idle_cnt_q + 8'd1;
                        if (idle_cnt_d == IDLE_L && cur_floor != HOME_L && !home_hold_q) begin
                            state_d = HOMING;
                            call_d  = HOME_L;
                        end
                    end
                end
                MOVE: begin
                    if (tgt_valid) begin
                        call_d     = tgt;
                        dir_pref_d = tgt_dir;
                        if (tgt == cur_floor && door) begin
                            state_d     = DWELL;
                            dwell_cnt_d = DWELL_L;
                        end
                    end else begin
                        state_d    = IDLE;
                        idle_cnt_d = 8'd0;
                    end
                end
                DWELL: begin
                    call_d = cur_floor;
                    // A press for this floor on the completion cycle reopens the door: dwell again
                    if (door && dwell_cnt_q <= 4'd1) begin
                        clear_mask  = cur_onehot;
                        home_hold_d = 1'b0;
                        if (req_btn[cur_floor]) begin
                            dwell_cnt_d = DWELL_L;
                        end else begin
                            dwell_cnt_d = 4'd0;
                            if (((pending_q & ~cur_onehot) | req_btn) != 4'b0000) begin
                                state_d = MOVE;
                            end else begin
                                state_d    = IDLE;
                                idle_cnt_d = 8'd0;
                            end
                        end
                    end else if (req_btn[cur_floor]) begin
                        dwell_cnt_d = DWELL_L;
                    end else if (door) begin
                        dwell_cnt_d = dwell_cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        pending_d = (pending_q & ~clear_mask) | req_btn;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            call_q      <= HOME_L;
            pending_q   <= 4'b0000;
            dir_pref_q  <= 1'b1;
            busy_q      <= 1'b0;
            dwell_cnt_q <= 4'd0;
            idle_cnt_q  <= 8'd0;
            home_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            call_q      <= call_d;
            pending_q   <= pending_d;
            dir_pref_q  <= dir_pref_d;
            busy_q      <= busy_d;
            dwell_cnt_q <= dwell_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            home_hold_q <= home_hold_d;
        end
    end

    assign call     = call_q;
    assign pending  = pending_q;
    assign dir_pref = dir_pref_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_call_scheduler.sv
// tb/tb_call_scheduler.sv - directed vector bench for call_scheduler
module tb_call_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_btn;
    logic [1:0] cur_floor;
    logic       door;
    logic       emergency;
    logic [1:0] call;
    logic [3:0] pending;
    logic       dir_pref;
    logic       busy;

    int tests = 0;
    int fails = 0;

    call_scheduler dut (
        .clk(clk), .rst(rst), .req_btn(req_btn), .cur_floor(cur_floor),
        .door(door), .emergency(emergency), .call(call), .pending(pending),
        .dir_pref(dir_pref), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic [1:0] c;
        logic       d;
        logic       e;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [1:0] c,
                                input logic d, input logic e, input logic [1:0] ec,
                                input logic [3:0] ep, input logic edir, input logic eb);
        vec_t v;
        v.r = r; v.q = q; v.c = c; v.d = d; v.e = e;
        v.exp = {ec, ep, edir, eb};
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {call, pending, dir_pref, busy};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got call=%0d pend=%b dir=%b busy=%b, want call=%0d pend=%b dir=%b busy=%b",
                     name, got[7:6], got[5:2], got[1], got[0], exp[7:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [1:0] c,
                         input logic d, input logic e);
        rst = r; req_btn = q; cur_floor = c; door = d; emergency = e;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        check("reset_defaults", {2'd0, 4'b0000, 1'b1, 1'b0});

        // single request to floor 3 from floor 0
        vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 3'd0, 4'b1000, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 2'd3, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 2'd3, 4'b1000, 1, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b0000, 3, 1, 0, 2'd3, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 3, 1, 0, 2'd3, 4'b0000, 1, 0));
        // SCAN: serve 3 first, then reverse toward 0
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b1001, 1, 0, 0, 2'd0, 4'b1001, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 2'd3, 4'b1001, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 0, 0, 2'd3, 4'b1001, 1, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b0000, 3, 1, 0, 2'd3, 4'b1001, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 3, 1, 0, 2'd3, 4'b0001, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 3, 0, 0, 2'd0, 4'b0001, 0, 1));
        // emergency freezes a dwell with two door-open cycles left
        vecs.push_back(mk(1, 4'b0000, 2, 0, 0, 2'd0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 2, 0, 0, 2'd0, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 2, 0, 0, 2'd2, 4'b0100, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 1, 0, 2'd2, 4'b0100, 1, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b0001, 2, 1, 1, 2'd2, 4'b0101, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 1, 0, 2'd2, 4'b0101, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 1, 0, 2'd2, 4'b0001, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 0, 0, 2'd0, 4'b0001, 0, 1));
        // press for the current floor on the dwell-completion cycle
        vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 2'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 2'd1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 2'd1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 2'd1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 1, 1, 0, 2'd1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 2'd1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 2'd1, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 2'd1, 4'b0000, 1, 0));
        // pre-emption by floor 2 while heading for 3, ends mid-move with pending 1010
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 2'd0, 4'b1000, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 2'd3, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 2'd3, 4'b1100, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 2'd2, 4'b1100, 1, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b0000, 2, 1, 0, 2'd2, 4'b1100, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 1, 0, 2'd2, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 2, 0, 0, 2'd3, 4'b1000, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 2, 0, 0, 2'd3, 4'b1010, 1, 1));

        rst = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].q, vecs[i].c, vecs[i].d, vecs[i].e);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // asynchronous reset mid-move, observed before any clock edge
        drive(1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        #1;
        check("async_reset", {2'd0, 4'b0000, 1'b1, 1'b0});
        step();
        rst = 1'b0;

        // homing from floor 2 after the idle timeout, then no repeat homing
        for (int i = 0; i < 7; i++) step();
        check("home_not_early", {2'd0, 4'b0000, 1'b1, 1'b0});
        step();
        check("home_start", {2'd0, 4'b0000, 1'b1, 1'b1});
        step();
        check("home_still_moving", {2'd0, 4'b0000, 1'b1, 1'b1});
        cur_floor = 2'd0;
        step();
        check("home_arrive", {2'd0, 4'b0000, 1'b1, 1'b0});
        cur_floor = 2'd2;
        for (int i = 0; i < 12; i++) step();
        check("home_hold", {2'd0, 4'b0000, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
